// File: rtl/power_sequencer.sv
// Ordered power-rail sequencer with per-rail power-good checks, settle delays,
// timed shutdown, and a latched emergency-off on any rail or monitor fault.
module power_sequencer #(
    parameter int NUM_RAILS     = 3,
    parameter int SETTLE_CYCLES = 1000,
    parameter int PGOOD_TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear_fault,
    input  logic [NUM_RAILS-1:0] pgood,
    input  logic                 monitor_error,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 monitor_start,
    output logic                 ready,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [2:0]           fault_rail,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UP_WAIT   = 3'd1,
        S_UP_SETTLE = 3'd2,
        S_ON        = 3'd3,
        S_DOWN      = 3'd4,
        S_FAULT     = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
    logic                 mon_q, mon_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic [1:0]           code_q, code_d;
    logic [2:0]           frail_q, frail_d;

    logic [NUM_RAILS-1:0] cur_sel, nxt_sel;
    logic                 pg_cur, lost, active, mon_err, tmo;
    logic                 fault_hit, settle_done, last_rail;
    logic [2:0]           lost_rail;
    logic [1:0]           fcode;
    logic [2:0]           frail;

    assign active = (state_q == S_UP_WAIT) || (state_q == S_UP_SETTLE)
                 || (state_q == S_ON);

    // A rail counts as "up" once its own UP_WAIT is behind it.
    always_comb begin
        cur_sel   = '0;
        nxt_sel   = '0;
        pg_cur    = 1'b0;
        lost      = 1'b0;
        lost_rail = '0;
        for (int i = 0; i < NUM_RAILS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_sel[i] = 1'b1;
                pg_cur     = pgood[i];
            end
            if (idx_q + 3'd1 == 3'(i)) nxt_sel[i] = 1'b1;
        end
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (active && rail_en_q[i] && !pgood[i] &&
                ((3'(i) < idx_q) ||
                 ((3'(i) == idx_q) && (state_q != S_UP_WAIT)))) begin
                lost      = 1'b1;
                lost_rail = 3'(i);
            end
        end
    end

    assign mon_err     = (state_q == S_ON) && monitor_error;
    assign tmo         = (state_q == S_UP_WAIT) && !pg_cur
                      && (cnt_q == 16'(PGOOD_TIMEOUT - 1));
    assign fault_hit   = lost || mon_err || tmo;
    assign settle_done = (cnt_q == 16'(SETTLE_CYCLES - 1));
    assign last_rail   = (idx_q == 3'(NUM_RAILS - 1));
    assign fcode       = lost ? 2'd2 : (mon_err ? 2'd3 : 2'd1);
    assign frail       = lost ? lost_rail : (mon_err ? 3'd0 : idx_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            rail_en_q <= '0;
            mon_q     <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= '0;
            frail_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rail_en_q <= rail_en_d;
            mon_q     <= mon_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            frail_q   <= frail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (start && !stop) state_d = S_UP_WAIT;
            S_UP_WAIT:
                if (fault_hit)   state_d = S_FAULT;
                else if (stop)   state_d = (idx_q == 3'd0) ? S_IDLE : S_DOWN;
                else if (pg_cur) state_d = S_UP_SETTLE;
            S_UP_SETTLE:
                if (fault_hit)        state_d = S_FAULT;
                else if (stop)        state_d = (idx_q == 3'd0) ? S_IDLE : S_DOWN;
                else if (settle_done) state_d = last_rail ? S_ON : S_UP_WAIT;
            S_ON:
                if (fault_hit)   state_d = S_FAULT;
                else if (stop)   state_d = (idx_q == 3'd0) ? S_IDLE : S_DOWN;
            S_DOWN:
                if (settle_done && idx_q == 3'd0) state_d = S_IDLE;
            S_FAULT:
                if (clear_fault && !start) state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        rail_en_d = rail_en_q;
        mon_d     = mon_q;
        ready_d   = ready_q;
        fault_d   = fault_q;
        code_d    = code_q;
        frail_d   = frail_q;
        cnt_d     = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
        unique case (state_q)
            S_IDLE:
                if (state_d == S_UP_WAIT) begin
                    rail_en_d = NUM_RAILS'(1);
                    idx_d     = '0;
                end
            S_UP_WAIT, S_UP_SETTLE, S_ON:
                if (state_d == S_FAULT) begin
                    rail_en_d = '0;
                    mon_d     = 1'b0;
                    ready_d   = 1'b0;
                    fault_d   = 1'b1;
                    code_d    = fcode;
                    frail_d   = frail;
                end else if (state_d == S_DOWN || state_d == S_IDLE) begin
                    rail_en_d = rail_en_q & ~cur_sel;
                    mon_d     = 1'b0;
                    ready_d   = 1'b0;
                    idx_d     = (idx_q == 3'd0) ? 3'd0 : idx_q - 3'd1;
                end else if (state_q == S_UP_SETTLE && state_d == S_UP_WAIT) begin
                    rail_en_d = rail_en_q | nxt_sel;
                    idx_d     = idx_q + 3'd1;
                end else if (state_q == S_UP_SETTLE && state_d == S_ON) begin
                    mon_d     = 1'b1;
                    ready_d   = 1'b1;
                end
            S_DOWN:
                if (settle_done) begin
                    rail_en_d = rail_en_q & ~cur_sel;
                    idx_d     = (idx_q == 3'd0) ? 3'd0 : idx_q - 3'd1;
                    cnt_d     = '0;
                end
            S_FAULT:
                if (state_d == S_IDLE) begin
                    fault_d = 1'b0;
                    code_d  = '0;
                    frail_d = '0;
                end
            default: ;
        endcase
    end

    assign rail_en       = rail_en_q;
    assign monitor_start = mon_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign fault_code    = code_q;
    assign fault_rail    = frail_q;
    assign state         = state_q;

endmodule
